hangman_draw_scheduler: RTL
===========================

// Module: hangman_draw_scheduler
// PURPOSE
//  Draw-command controller in front of the vga_adapter frame-buffer write port (x, y, colour, plot).
//  Accepts three request types: full-screen clear, 8x8 glyph tile (letter or dash), filled rectangle (gallows/body part).
//  Arbitrates between them and rasterises the winning command one pixel per clock.
//  Fetches glyph bitmaps from the letter_ram ROM; owns that ROM's address port.
// PARAMETERS
//  XMAX       320     screen width in pixels
//  YMAX       240     screen height in pixels
//  BG_COLOUR  3'b000  colour written for unset glyph bits and erased tiles
// PORTS
//  clk           in   1   system clock
//  resetn        in   1   asynchronous, active-low reset
//  clr_req       in   1   request full-screen clear
//  clr_colour    in   3   clear colour
//  glyph_req     in   1   request 8x8 glyph tile draw
//  glyph_code    in   5   glyph ROM index (letters 0-25, dash 27)
//  glyph_x       in   9   tile top-left x
//  glyph_y       in   8   tile top-left y
//  glyph_colour  in   3   foreground colour
//  glyph_show    in   1   1 = draw bitmap; 0 = erase tile to BG_COLOUR
//  rect_req      in   1   request filled-rectangle draw
//  rect_x0       in   9   rectangle top-left x
//  rect_y0       in   8   rectangle top-left y
//  rect_w        in   6   rectangle width in pixels (0 = empty)
//  rect_h        in   6   rectangle height in pixels (0 = empty)
//  rect_colour   in   3   fill colour
//  clr_done      out  1   1-cycle pulse: clear finished
//  glyph_done    out  1   1-cycle pulse: glyph finished
//  rect_done     out  1   1-cycle pulse: rectangle finished
//  busy          out  1   1 whenever state != IDLE
//  rom_addr      out  5   glyph ROM address (1-cycle read latency)
//  rom_q         in   64  glyph bitmap; bit {col[2:0],row[2:0]} = pixel (col,row)
//  vga_x         out  9   pixel x
//  vga_y         out  8   pixel y
//  vga_colour    out  3   pixel colour
//  vga_plot      out  1   pixel write enable
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE.
//  Reset mid-command: aborts the command; no done pulse is issued.
//  Requests are sampled only in IDLE.
//    - Priority: clr > glyph > rect; fixed priority, no fairness; losing requests stay pending.
//    - At the accepting edge E, all operands of the winning command are latched.
//    - The requester holds req high until its done pulse, then drops it.
//    - IDLE ignores requests during the cycle in which any done pulse is high (prevents replay).
//  FSM states: IDLE, CLR, GFETCH, GWAIT, GDRAW, RECT.
//  All vga_* outputs are registered.
//  CLR
//    - Row-major scan: x from 0 to XMAX-1, inner loop; y from 0 to YMAX-1, outer loop.
//    - plot=1 every cycle, colour = clr_colour.
//    - Plots occur at cycles E+1 .. E+76800; clr_done at E+76801.
//  GFETCH
//    - rom_addr = glyph_code is registered at E.
//    - GWAIT is entered at E+1.
//    - At E+2, rom_q is captured into a 64-bit register and GDRAW is entered.
//  GDRAW
//    - Index i runs 0..63; col = i[5:3], row = i[2:0].
//    - Pixel position: x = glyph_x + col, y = glyph_y + row.
//    - colour = (glyph_show & bit[i]) ? glyph_colour : BG_COLOUR.
//    - Plots at E+3 .. E+66; glyph_done at E+67.
//  RECT
//    - Row-major over w x h pixels; colour = rect_colour.
//    - Plots at E+1 .. E+w*h; rect_done at E+w*h+1.
//    - w==0 or h==0: no plots; rect_done at E+1.
//  Clipping
//    - Sums are computed 10 bits wide, so no wrap-around.
//    - A pixel with x >= XMAX or y >= YMAX is emitted with plot=0.
//    - Clipped pixels still consume their cycle, so timing is unchanged.
//  Between commands: vga_plot=0; vga_x, vga_y and vga_colour hold their last values.
// STRUCTURE
//  Package hangman_vga_pkg holds:
//    - the state enum;
//    - XMAX, YMAX and BG_COLOUR defaults;
//    - GLYPH_DASH = 5'd27;
//    - colour constants.
//  Sub-module raster_counter: 2-D counter with start, width and height inputs.
//    - Outputs col, row, valid and last.
//    - Shared by the CLR, GDRAW (8x8) and RECT paths.
// TESTING
//  1. clr_req=1, colour 3'b000:
//     76800 plots, scanning (0,0)..(319,239); clr_done exactly once at E+76801.
//  2. glyph_req, code 0, at (20,200), show=1, ROM bitmap 64'h1:
//     rom_addr=0 at E; plot at E+3 writes (20,200) in fg; the other 63 pixels get BG_COLOUR; done at E+67.
//  3. rect (316,238), w=8, h=4:
//     32 plot cycles; only x 316..319 and y 238..239 have plot=1; done at E+33.
//  4. clr_req, glyph_req and rect_req raised in the same cycle:
//     order is clear, then glyph, then rect; each done pulses once; no request is replayed.
//  5. rect with w=0:
//     no plots; rect_done at E+1.
//     Glyph with show=0: all 64 pixels written BG_COLOUR.
//  6. resetn pulsed low mid-CLR:
//     all outputs go to 0 asynchronously; no clr_done.
//     After release, a glyph request executes normally.

Source files
------------

// File: rtl/hangman_vga_pkg.sv
// Shared types and constants for the hangman VGA draw path.
package hangman_vga_pkg;

  // Draw scheduler states.
  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StGfetch,
    StGwait,
    StGdraw,
    StRect
  } state_e;

  localparam int unsigned XMAX_DEFAULT      = 320;
  localparam int unsigned YMAX_DEFAULT      = 240;
  localparam logic [2:0]  BG_COLOUR_DEFAULT = 3'b000;

  localparam logic [4:0]  GLYPH_DASH = 5'd27;
  localparam int unsigned GLYPH_DIM  = 8;

  localparam logic [2:0] COLOUR_BLACK   = 3'b000;
  localparam logic [2:0] COLOUR_BLUE    = 3'b001;
  localparam logic [2:0] COLOUR_GREEN   = 3'b010;
  localparam logic [2:0] COLOUR_CYAN    = 3'b011;
  localparam logic [2:0] COLOUR_RED     = 3'b100;
  localparam logic [2:0] COLOUR_MAGENTA = 3'b101;
  localparam logic [2:0] COLOUR_YELLOW  = 3'b110;
  localparam logic [2:0] COLOUR_WHITE   = 3'b111;

endpackage

// File: rtl/hangman_draw_scheduler_raster_counter.sv
// 2-D raster counter: col is the inner (fast) index, row the outer one.
// A start loads the extents and restarts at (0,0); an empty extent never goes valid.
module raster_counter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [8:0] width_i,
  input  logic [7:0] height_i,
  output logic [8:0] col_o,
  output logic [7:0] row_o,
  output logic       valid_o,
  output logic       last_o
);

  logic [8:0] col_q, col_d, w_q, w_d;
  logic [7:0] row_q, row_d, h_q, h_d;
  logic       valid_q, valid_d;
  logic       col_end, row_end;

  // Next position: advance every cycle while valid, drop valid after the last point.
  always_comb begin
    col_end = (col_q == w_q - 9'd1);
    row_end = (row_q == h_q - 8'd1);
    last_o  = valid_q && col_end && row_end;
    col_d   = col_q;
    row_d   = row_q;
    w_d     = w_q;
    h_d     = h_q;
    valid_d = valid_q;
    if (start_i) begin
      col_d   = '0;
      row_d   = '0;
      w_d     = width_i;
      h_d     = height_i;
      valid_d = (width_i != 9'd0) && (height_i != 8'd0);
    end else if (valid_q) begin
      if (col_end) begin
        col_d = '0;
        if (row_end) begin
          valid_d = 1'b0;
        end else begin
          row_d = row_q + 8'd1;
        end
      end else begin
        col_d = col_q + 9'd1;
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q   <= '0;
      row_q   <= '0;
      w_q     <= '0;
      h_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      w_q     <= w_d;
      h_q     <= h_d;
      valid_q <= valid_d;
    end
  end

  assign col_o   = col_q;
  assign row_o   = row_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/hangman_draw_scheduler.sv
// Draw-command scheduler: arbitrates clear / glyph / rectangle requests and
// rasterises the winner one pixel per clock into the frame-buffer write port.
module hangman_draw_scheduler
  import hangman_vga_pkg::*;
#(
  parameter int unsigned XMAX      = XMAX_DEFAULT,
  parameter int unsigned YMAX      = YMAX_DEFAULT,
  parameter logic [2:0]  BG_COLOUR = BG_COLOUR_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clr_req,
  input  logic [2:0]  clr_colour,
  input  logic        glyph_req,
  input  logic [4:0]  glyph_code,
  input  logic [8:0]  glyph_x,
  input  logic [7:0]  glyph_y,
  input  logic [2:0]  glyph_colour,
  input  logic        glyph_show,
  input  logic        rect_req,
  input  logic [8:0]  rect_x0,
  input  logic [7:0]  rect_y0,
  input  logic [5:0]  rect_w,
  input  logic [5:0]  rect_h,
  input  logic [2:0]  rect_colour,
  output logic        clr_done,
  output logic        glyph_done,
  output logic        rect_done,
  output logic        busy,
  output logic [4:0]  rom_addr,
  input  logic [63:0] rom_q,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot
);

  localparam logic [8:0] XMaxCnt = 9'(XMAX);
  localparam logic [7:0] YMaxCnt = 8'(YMAX);
  localparam logic [9:0] XMaxW   = 10'(XMAX);
  localparam logic [9:0] YMaxW   = 10'(YMAX);

  state_e      state_q, state_d;
  logic [8:0]  base_x_q, base_x_d;
  logic [7:0]  base_y_q, base_y_d;
  logic [2:0]  colour_q, colour_d;
  logic        show_q, show_d;
  logic [63:0] bits_q, bits_d;
  logic [4:0]  rom_addr_q, rom_addr_d;
  logic [8:0]  vga_x_q, vga_x_d;
  logic [7:0]  vga_y_q, vga_y_d;
  logic [2:0]  vga_colour_q, vga_colour_d;
  logic        vga_plot_q, vga_plot_d;
  logic        clr_done_q, clr_done_d;
  logic        glyph_done_q, glyph_done_d;
  logic        rect_done_q, rect_done_d;

  logic        cnt_start;
  logic [8:0]  cnt_w;
  logic [7:0]  cnt_h;
  logic [8:0]  cnt_col;
  logic [7:0]  cnt_row;
  logic        cnt_valid;
  logic        cnt_last;
  logic        unused_cnt_last;

  logic [9:0]  px_x, px_y;
  logic [2:0]  pix_colour;
  logic        in_bounds;
  logic        any_done;

  raster_counter u_raster (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .start_i (cnt_start),
    .width_i (cnt_w),
    .height_i(cnt_h),
    .col_o   (cnt_col),
    .row_o   (cnt_row),
    .valid_o (cnt_valid),
    .last_o  (cnt_last)
  );

  // End of scan is taken from valid dropping, which also covers empty rectangles.
  assign unused_cnt_last = cnt_last;
  assign any_done        = clr_done_q | glyph_done_q | rect_done_q;

  // Current pixel: glyphs scan column-major (bit index {col,row}), so the counter's
  // fast index is the glyph row. Sums are 10 bits so off-screen pixels never wrap.
  always_comb begin
    if (state_q == StGdraw) begin
      px_x       = {1'b0, base_x_q} + {7'b0, cnt_row[2:0]};
      px_y       = {2'b0, base_y_q} + {7'b0, cnt_col[2:0]};
      pix_colour = (show_q && bits_q[{cnt_row[2:0], cnt_col[2:0]}]) ? colour_q : BG_COLOUR;
    end else begin
      px_x       = {1'b0, base_x_q} + {1'b0, cnt_col};
      px_y       = {2'b0, base_y_q} + {2'b0, cnt_row};
      pix_colour = colour_q;
    end
    in_bounds = (px_x < XMaxW) && (px_y < YMaxW);
  end

  // Arbitration, next state and registered pixel outputs.
  always_comb begin
    state_d      = state_q;
    base_x_d     = base_x_q;
    base_y_d     = base_y_q;
    colour_d     = colour_q;
    show_d       = show_q;
    bits_d       = bits_q;
    rom_addr_d   = rom_addr_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    clr_done_d   = 1'b0;
    glyph_done_d = 1'b0;
    rect_done_d  = 1'b0;
    cnt_start    = 1'b0;
    cnt_w        = XMaxCnt;
    cnt_h        = YMaxCnt;

    case (state_q)
      StIdle: begin
        // A done pulse in flight means its requester has not yet dropped req.
        if (!any_done) begin
          if (clr_req) begin
            base_x_d  = '0;
            base_y_d  = '0;
            colour_d  = clr_colour;
            cnt_start = 1'b1;
            state_d   = StClr;
          end else if (glyph_req) begin
            base_x_d   = glyph_x;
            base_y_d   = glyph_y;
            colour_d   = glyph_colour;
            show_d     = glyph_show;
            rom_addr_d = glyph_code;
            state_d    = StGfetch;
          end else if (rect_req) begin
            base_x_d  = rect_x0;
            base_y_d  = rect_y0;
            colour_d  = rect_colour;
            cnt_w     = {3'b0, rect_w};
            cnt_h     = {2'b0, rect_h};
            cnt_start = 1'b1;
            state_d   = StRect;
          end
        end
      end
      StGfetch: state_d = StGwait;
      StGwait: begin
        bits_d    = rom_q;
        cnt_w     = 9'(GLYPH_DIM);
        cnt_h     = 8'(GLYPH_DIM);
        cnt_start = 1'b1;
        state_d   = StGdraw;
      end
      StClr, StGdraw, StRect: begin
        if (cnt_valid) begin
          vga_x_d      = px_x[8:0];
          vga_y_d      = px_y[7:0];
          vga_colour_d = pix_colour;
          vga_plot_d   = in_bounds;
        end else begin
          state_d      = StIdle;
          clr_done_d   = (state_q == StClr);
          glyph_done_d = (state_q == StGdraw);
          rect_done_d  = (state_q == StRect);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any command without a done pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      base_x_q     <= '0;
      base_y_q     <= '0;
      colour_q     <= '0;
      show_q       <= 1'b0;
      bits_q       <= '0;
      rom_addr_q   <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      clr_done_q   <= 1'b0;
      glyph_done_q <= 1'b0;
      rect_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_x_q     <= base_x_d;
      base_y_q     <= base_y_d;
      colour_q     <= colour_d;
      show_q       <= show_d;
      bits_q       <= bits_d;
      rom_addr_q   <= rom_addr_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      clr_done_q   <= clr_done_d;
      glyph_done_q <= glyph_done_d;
      rect_done_q  <= rect_done_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign rom_addr   = rom_addr_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign clr_done   = clr_done_q;
  assign glyph_done = glyph_done_q;
  assign rect_done  = rect_done_q;

endmodule
